seq_countdown_arb_ctrl: RTL and testbench
=========================================

// Module: seq_countdown_arb_ctrl
// PURPOSE
//   Round-robin scheduler that shares one 3-bit binary down counter among NREQ requesters.
//   Each requester hands over a start value through a val/rdy handshake.
//   The controller loads the counter, sequences the decrement down to 0 (honouring pause),
//   then returns a one-cycle done pulse to the owner.
//   Sits between job-issuing blocks and the shared down-counter datapath.
// PARAMETERS
//   NREQ    2  number of requesters (>=2)
//   NBITS   3  counter width
//   OWNER_W 1  owner index width, $clog2(NREQ) (min 1)
// PORTS
//   clk        in   1           clock, all state updates on rising edge
//   reset      in   1           asynchronous, active-low; 0 clears all state immediately
//   req_val    in   NREQ        requester i has a job
//   req_rdy    out  NREQ        one-hot grant; handshake fires when req_val[i] & req_rdy[i]
//   req_count  in   NREQ*NBITS  start values, requester i at [i*NBITS +: NBITS]
//   pause      in   1           1 = hold counter this cycle (RUN state only)
//   busy       out  1           1 when state != IDLE
//   owner      out  OWNER_W     index of current/last granted requester
//   count      out  NBITS       current counter value
//   done       out  NREQ        one-hot, one-cycle pulse to owner at job completion
// BEHAVIOUR
//   Reset values: state=IDLE, count=0, owner=0, done=0, busy=0, rr pointer=0.
//   req_rdy is combinational from req_val in IDLE.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE:
//       * req_rdy = one-hot grant to the first valid requester at or after the rr pointer
//         (circular); 0 if none valid.
//       * On fire: count<=req_count[i], owner<=i, ptr<=(i+1)%NREQ.
//       * Next state RUN if the loaded value != 0; DONE if it == 0.
//   - RUN:
//       * req_rdy=0.
//       * pause=1: count holds.
//       * pause=0 and count>1: count<=count-1.
//       * pause=0 and count==1: count<=0, go to DONE.
//   - DONE: done[owner]=1 for exactly this cycle, count=0, req_rdy=0, then IDLE.
//   Latency: with a fire at cycle 0 and start value N>=1 (no pause):
//     * count=N at cycle 1, N-1 at cycle 2, ... 1 at cycle N;
//     * count=0 and done at cycle N+1;
//     * next fire possible at cycle N+2.
//     * Each paused RUN cycle adds 1 cycle.
//   Start value 0: DONE at cycle 1.
//   No wrap-around: the controller never enables a decrement at count==0.
//   Counter range is 7..0; the value after 0 is never 7.
//   pause is ignored in IDLE and DONE.
//   A requester whose val drops without a fire loses nothing; the pointer only moves on a fire.
//   Asynchronous reset mid-RUN or mid-DONE:
//     * job is aborted with no done pulse;
//     * all outputs return to reset values immediately;
//     * rr pointer returns to 0.
//   After reset deasserts, the first edge behaves as IDLE.
// STRUCTURE
//   Shared package seq_countdown_pkg:
//     * typedef enum {IDLE,RUN,DONE} state_t;
//     * localparams NBITS=3, NREQ=2.
//   Sub-module seq_count_bin_dn_ld:
//     * NBITS down counter with ports ld, ld_val, en;
//     * async active-low reset to 0;
//     * ld has priority over en;
//     * wraps 0->max if en at 0 (never exercised by this controller).
//   Controller holds the FSM, the rr pointer and the owner register.
//   The arbiter is combinational inside the controller.
// TESTING
//   1. Single req0 with count=3, req1 idle:
//      fire at c0 -> count 3,2,1 at c1..c3; count=0 and done=2'b01 at c4; busy=1 c1..c4.
//   2. Both val after reset, req0=2, req1=5, held valid:
//      * grant req0 first;
//      * after its done, grant req1 (pointer moved to 1);
//      * next grant goes back to req0.
//   3. req1 with count=0: fire at c0 -> done=2'b10 at c1, busy=1 only at c1, no RUN cycle.
//   4. req0 with count=4, pause=1 at c2 and c3:
//      count 4,3,3,3,2,1 at c1..c6; done at c7 (2 cycles late).
//   5. req0 with count=6, reset driven to 0 while count=3:
//      * count=0, busy=0, done=0 immediately, with no done pulse ever;
//      * after release, req1 and req0 both valid -> req0 granted (pointer=0).
//   6. req1 with count=7:
//      count 7..1 at c1..c7, 0 with done at c8; count never 7 again before the next load.

Source files
------------

// File: rtl/seq_countdown_pkg.sv
// Shared types and default sizing for the round-robin countdown scheduler.
package seq_countdown_pkg;

    localparam int unsigned NBITS = 3;
    localparam int unsigned NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/seq_count_bin_dn_ld.sv
// Loadable binary down counter; load takes priority over decrement, wraps at 0.
module seq_count_bin_dn_ld #(
    parameter int unsigned NBITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [NBITS-1:0] ld_val,
    input  logic             en,
    output logic [NBITS-1:0] cnt
);

    logic [NBITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_countdown_arb_ctrl.sv
// Round-robin scheduler sharing one down counter among NREQ requesters,
// pulsing done to the owner when its job reaches zero.
module seq_countdown_arb_ctrl #(
    parameter int unsigned NREQ    = seq_countdown_pkg::NREQ,
    parameter int unsigned NBITS   = seq_countdown_pkg::NBITS,
    parameter int unsigned OWNER_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_val,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [NREQ*NBITS-1:0]  req_count,
    input  logic                   pause,
    output logic                   busy,
    output logic [OWNER_W-1:0]     owner,
    output logic [NBITS-1:0]       count,
    output logic [NREQ-1:0]        done
);

    import seq_countdown_pkg::*;

    state_t               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   ptr_q, ptr_d;
    logic [NBITS-1:0]     cnt;
    logic [NBITS-1:0]     ld_val;
    logic [OWNER_W-1:0]   grant_idx, grant_nxt;
    logic                 grant_found;
    logic                 fire;
    logic                 cnt_en;

    // Circular priority: first pass covers indices at/after the pointer, second wraps to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_found && req_val[i] && (OWNER_W'(i) >= ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = OWNER_W'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_found && req_val[i]) begin
                grant_found = 1'b1;
                grant_idx   = OWNER_W'(i);
            end
        end
    end

    always_comb begin
        ld_val    = '0;
        grant_nxt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == OWNER_W'(i)) begin
                ld_val    = req_count[i*NBITS +: NBITS];
                grant_nxt = (i == NREQ - 1) ? '0 : OWNER_W'(i + 1);
            end
        end
    end

    assign fire   = (state_q == IDLE) && grant_found;
    // Guard against decrementing at zero so the counter never wraps to max.
    assign cnt_en = (state_q == RUN) && !pause && (cnt != '0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    owner_d = grant_idx;
                    ptr_d   = grant_nxt;
                    state_d = (ld_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!pause && (cnt == NBITS'(1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    seq_count_bin_dn_ld #(
        .NBITS (NBITS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (fire),
        .ld_val (ld_val),
        .en     (cnt_en),
        .cnt    (cnt)
    );

    always_comb begin
        req_rdy = '0;
        done    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_rdy[i] = fire && (grant_idx == OWNER_W'(i));
            done[i]    = (state_q == DONE) && (owner_q == OWNER_W'(i));
        end
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;
    assign count = cnt;

endmodule

// File: tb/tb_seq_countdown_arb_ctrl.sv
// Directed table-driven bench for the round-robin countdown scheduler.
module tb_seq_countdown_arb_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] req_val;
    logic [1:0] req_rdy;
    logic [5:0] req_count;
    logic       pause;
    logic       busy;
    logic [0:0] owner;
    logic [2:0] count;
    logic [1:0] done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] val;
        logic [2:0] c0;
        logic [2:0] c1;
        logic       pause;
        logic [1:0] rdy;
        logic       busy;
        logic       owner;
        logic [2:0] cnt;
        logic [1:0] dn;
    } vec_t;

    vec_t vecs[$];

    seq_countdown_arb_ctrl #(
        .NREQ    (2),
        .NBITS   (3),
        .OWNER_W (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_count (req_count),
        .pause     (pause),
        .busy      (busy),
        .owner     (owner),
        .count     (count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [1:0] val, input logic [2:0] c0, input logic [2:0] c1,
                       input logic p, input logic [1:0] rdy, input logic bsy,
                       input logic own, input logic [2:0] cnt, input logic [1:0] dn);
        vec_t v;
        v.val = val; v.c0 = c0; v.c1 = c1; v.pause = p;
        v.rdy = rdy; v.busy = bsy; v.owner = own; v.cnt = cnt; v.dn = dn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [1:0] e_rdy, input logic e_busy,
                       input logic e_owner, input logic [2:0] e_cnt, input logic [1:0] e_dn);
        checks++;
        if ({req_rdy, busy, owner, count, done} !== {e_rdy, e_busy, e_owner, e_cnt, e_dn}) begin
            errors++;
            $display("FAIL %s: got rdy=%b busy=%b owner=%0d count=%0d done=%b, expected rdy=%b busy=%b owner=%0d count=%0d done=%b",
                     nm, req_rdy, busy, owner, count, done, e_rdy, e_busy, e_owner, e_cnt, e_dn);
        end
    endtask

    initial begin
        // Job A: req0 start 3, req1 idle
        add(2'b01, 3, 0, 0, 2'b00, 1, 0, 3, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 2, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 2'b01);
        add(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
        // Job B: req1 start 0 goes straight to DONE
        add(2'b10, 0, 0, 0, 2'b00, 1, 1, 0, 2'b10);
        add(2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00);
        // Job C: both valid, req0=2, req1=5, round-robin alternation
        add(2'b11, 2, 5, 0, 2'b00, 1, 0, 2, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 0, 1, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 0, 0, 2'b01);
        add(2'b11, 2, 5, 0, 2'b10, 0, 0, 0, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 1, 5, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 1, 4, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 1, 3, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 1, 2, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 1, 1, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 1, 0, 2'b10);
        add(2'b11, 2, 5, 0, 2'b01, 0, 1, 0, 2'b00);
        add(2'b11, 2, 5, 0, 2'b00, 1, 0, 2, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 2'b01);
        add(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
        // Job D: req0 start 4 with two paused cycles; pause in DONE ignored
        add(2'b01, 4, 0, 0, 2'b00, 1, 0, 4, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 3, 2'b00);
        add(2'b00, 0, 0, 1, 2'b00, 1, 0, 3, 2'b00);
        add(2'b00, 0, 0, 1, 2'b00, 1, 0, 3, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 2, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 2'b01);
        add(2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00);
        // Job E: req1 start 7, full range, no wrap afterwards
        add(2'b10, 0, 7, 0, 2'b00, 1, 1, 7, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 6, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 5, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 4, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 3, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 2, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 1, 2'b00);
        add(2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 2'b10);
        add(2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00);
        add(2'b00, 0, 0, 1, 2'b00, 0, 1, 0, 2'b00);

        reset     = 1'b0;
        req_val   = '0;
        req_count = '0;
        pause     = 1'b0;
        #12;
        chk("reset_state", 2'b00, 0, 0, 0, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            req_val   = vecs[i].val;
            req_count = {vecs[i].c1, vecs[i].c0};
            pause     = vecs[i].pause;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i), vecs[i].rdy, vecs[i].busy, vecs[i].owner,
                vecs[i].cnt, vecs[i].dn);
        end

        // Asynchronous reset in the middle of a RUN job
        req_val   = 2'b01;
        req_count = {3'd0, 3'd6};
        pause     = 1'b0;
        @(posedge clk); #1;
        chk("abort_load", 2'b00, 1, 0, 6, 2'b00);
        req_val = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_at3", 2'b00, 1, 0, 3, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_async_clear", 2'b00, 0, 0, 0, 2'b00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_hold%0d", k), 2'b00, 0, 0, 0, 2'b00);
        end
        @(negedge clk);
        reset     = 1'b1;
        req_val   = 2'b11;
        req_count = {3'd5, 3'd2};
        #1;
        chk("abort_ptr_cleared", 2'b01, 0, 0, 0, 2'b00);
        @(posedge clk); #1;
        chk("abort_regrant", 2'b00, 1, 0, 2, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
